// File: rtl/voq_tx_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : voq_tx_scheduler_pkg
// Description : Shared widths, header field offsets, FSM state type and
//               header field extractors for the VOQ transmit scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package voq_tx_scheduler_pkg;

  // Switch-wide build constants
  localparam int DATA_WIDTH      = 64;
  localparam int PORT_NUB_TOTAL  = 4;
  localparam int DATA_LENGTH_MAX = 16;
  localparam int PRIORITY        = 4;
  localparam int CRC32_LENGTH    = 32;

  // Derived widths
  localparam int WIDTH_DATA     = DATA_WIDTH;
  localparam int WIDTH_SEL      = $clog2(PORT_NUB_TOTAL);
  localparam int WIDTH_PORT     = WIDTH_SEL + WIDTH_DATA;
  localparam int WIDTH_LENGTH   = $clog2(DATA_LENGTH_MAX);
  localparam int WIDTH_PRIORITY = $clog2(PRIORITY);
  localparam int WIDTH_CRC      = CRC32_LENGTH;

  // Header word field positions
  localparam int PRIO_LSB = WIDTH_CRC;
  localparam int LEN_LSB  = WIDTH_CRC + WIDTH_PRIORITY;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BODY = 1'b1
  } sched_state_t;

  // Number of body words following the header
  function automatic logic [WIDTH_LENGTH-1:0] hdr_length(input logic [WIDTH_DATA-1:0] word);
    return word[LEN_LSB +: WIDTH_LENGTH];
  endfunction

  // Packet priority carried in the header
  function automatic logic [WIDTH_PRIORITY-1:0] hdr_priority(input logic [WIDTH_DATA-1:0] word);
    return word[PRIO_LSB +: WIDTH_PRIORITY];
  endfunction

endpackage
`default_nettype wire

// File: rtl/voq_tx_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. Requests are rotated so
//               that index ptr lands at bit 0 (double-width shift), the
//               lowest set bit is found, and the offset is added back to ptr.
//               An eligibility mask can remove requesters from the contest.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter  int N = 4,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  input  logic [N-1:0] mask,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx,
  output logic         any
);

  localparam logic [W:0] C_N = (W+1)'(N);

  logic [N-1:0] w_req;
  logic [N-1:0] w_rot;
  logic [W-1:0] w_off;
  logic [W:0]   w_sum;

  assign w_req = req & mask;
  // Duplicated vector shifted right by ptr: bit k of the result is requester (ptr+k) mod N
  assign w_rot = N'({w_req, w_req} >> ptr);
  assign any   = |w_req;

  // Lowest set bit of the rotated vector is the first requester at or after ptr
  always_comb begin
    w_off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = i[W-1:0];
    end
  end

  assign w_sum     = {1'b0, ptr} + {1'b0, w_off};
  assign grant_idx = (w_sum >= C_N) ? W'(w_sum - C_N) : w_sum[W-1:0];
  assign grant     = any ? (N'(1) << grant_idx) : '0;

endmodule
`default_nettype wire

// File: rtl/voq_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : voq_tx_scheduler
// Description : Per-output-port packet scheduler. Grants one whole packet at a
//               time from the VOQs, pops its words and emits them as a
//               registered stream tagged with source port and a per-packet
//               sequence number, honouring downstream back-pressure.
//               Optional macro PRIORITY_ARB_EN: header priority picks the
//               IDLE winner, ties resolved round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module voq_tx_scheduler
  import voq_tx_scheduler_pkg::*;
#(
  parameter int NUB      = 0,
  parameter int PORT_NUB = PORT_NUB_TOTAL
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [PORT_NUB-1:0]            req_in,
  input  logic [PORT_NUB*WIDTH_DATA-1:0] data_in,
  output logic [PORT_NUB-1:0]            rd_en_out,
  input  logic                           keep_in,
  output logic [WIDTH_PORT-1:0]          data_out,
  output logic [WIDTH_SEL-1:0]           nub_out,
  output logic                           valid_out,
  output logic                           busy_out
);

  // Widths come from the shared package, so the port count must match it
  if (NUB < 0 || NUB >= PORT_NUB_TOTAL || PORT_NUB != PORT_NUB_TOTAL) begin : g_bad_cfg
    $error("voq_tx_scheduler: NUB/PORT_NUB inconsistent with PORT_NUB_TOTAL");
  end

  sched_state_t            r_state;
  sched_state_t            w_state_nxt;
  logic [WIDTH_SEL-1:0]    r_rr_ptr;
  logic [WIDTH_SEL-1:0]    r_grant;
  logic [WIDTH_SEL-1:0]    r_nub;
  logic [WIDTH_LENGTH-1:0] r_len_cnt;

  logic [PORT_NUB-1:0]     w_mask;
  logic [PORT_NUB-1:0]     w_gnt_oh;
  logic [WIDTH_SEL-1:0]    w_gnt_idx;
  logic                    w_any;
  logic [WIDTH_SEL-1:0]    w_sel;
  logic [WIDTH_DATA-1:0]   w_word;
  logic [WIDTH_LENGTH-1:0] w_hdr_len;
  logic [WIDTH_SEL-1:0]    w_ptr_nxt;
  logic                    w_pop;
  logic                    w_pkt_end;

`ifdef PRIORITY_ARB_EN
  logic [WIDTH_PRIORITY-1:0] w_max_prio;

  // Highest header priority among requesters; every port carrying it stays eligible
  always_comb begin
    w_max_prio = '0;
    w_mask     = '0;
    for (int i = 0; i < PORT_NUB; i++) begin
      if (req_in[i] && (hdr_priority(data_in[i*WIDTH_DATA +: WIDTH_DATA]) > w_max_prio))
        w_max_prio = hdr_priority(data_in[i*WIDTH_DATA +: WIDTH_DATA]);
    end
    for (int i = 0; i < PORT_NUB; i++) begin
      w_mask[i] = (hdr_priority(data_in[i*WIDTH_DATA +: WIDTH_DATA]) == w_max_prio);
    end
  end
`else
  assign w_mask = '1;
`endif

  rr_arbiter #(
    .N (PORT_NUB)
  ) u_rr_arbiter (
    .req       (req_in),
    .ptr       (r_rr_ptr),
    .mask      (w_mask),
    .grant     (w_gnt_oh),
    .grant_idx (w_gnt_idx),
    .any       (w_any)
  );

  // Word source: arbiter winner for a header, held grant for body words
  assign w_sel     = (r_state == IDLE) ? w_gnt_idx : r_grant;
  assign w_word    = data_in[w_sel*WIDTH_DATA +: WIDTH_DATA];
  assign w_hdr_len = hdr_length(w_word);
  assign w_ptr_nxt = (w_sel == WIDTH_SEL'(PORT_NUB - 1)) ? '0 : w_sel + 1'b1;
  assign busy_out  = (r_state == BODY);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and pop strobe; a stall freezes the FSM and suppresses pops
  always_comb begin
    w_state_nxt = r_state;
    rd_en_out   = '0;
    unique case (r_state)
      IDLE: begin
        if (!keep_in && w_any) begin
          rd_en_out = w_gnt_oh;
          if (w_hdr_len != '0) w_state_nxt = BODY;
        end
      end
      BODY: begin
        if (!keep_in && req_in[r_grant]) begin
          rd_en_out[r_grant] = 1'b1;
          if (r_len_cnt == WIDTH_LENGTH'(1)) w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_pop     = |rd_en_out;
  // A pop that leaves the FSM in IDLE closes the packet (zero-length header or last body word)
  assign w_pkt_end = w_pop && (w_state_nxt == IDLE);

  // Output register, length counter, grant latch, round-robin pointer and sequence number
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out  <= '0;
      nub_out   <= '0;
      valid_out <= 1'b0;
      r_grant   <= '0;
      r_len_cnt <= '0;
      r_rr_ptr  <= '0;
      r_nub     <= '0;
    end else if (!keep_in) begin
      valid_out <= w_pop;
      if (w_pop) begin
        data_out <= {w_sel, w_word};
        nub_out  <= r_nub;
      end
      if (w_pop && (r_state == IDLE)) begin
        r_grant   <= w_gnt_idx;
        r_len_cnt <= w_hdr_len;
      end else if (w_pop) begin
        r_len_cnt <= r_len_cnt - 1'b1;
      end
      if (w_pkt_end) begin
        r_rr_ptr <= w_ptr_nxt;
        r_nub    <= r_nub + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_voq_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_voq_tx_scheduler
// Description : Scoreboard testbench for voq_tx_scheduler. VOQs are modelled
//               as word queues; a packet-level reference model predicts pops
//               and output words, a monitor compares the registered stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_voq_tx_scheduler;
  import voq_tx_scheduler_pkg::*;

  localparam int NP      = PORT_NUB_TOTAL;
  localparam int LEN_POS = WIDTH_CRC + WIDTH_PRIORITY;
  localparam int PRI_POS = WIDTH_CRC;
  localparam int NUB_MOD = 1 << WIDTH_SEL;

  logic                      clk;
  logic                      rst_n;
  logic [NP-1:0]             req_in;
  logic [NP*WIDTH_DATA-1:0]  data_in;
  logic [NP-1:0]             rd_en_out;
  logic                      keep_in;
  logic [WIDTH_PORT-1:0]     data_out;
  logic [WIDTH_SEL-1:0]      nub_out;
  logic                      valid_out;
  logic                      busy_out;

  voq_tx_scheduler #(
    .NUB      (0),
    .PORT_NUB (NP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_in    (req_in),
    .data_in   (data_in),
    .rd_en_out (rd_en_out),
    .keep_in   (keep_in),
    .data_out  (data_out),
    .nub_out   (nub_out),
    .valid_out (valid_out),
    .busy_out  (busy_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH_PORT-1:0] d;
    logic [WIDTH_SEL-1:0]  n;
  } exp_t;

  logic [WIDTH_DATA-1:0] vq [NP][$];
  exp_t                  sb [$];
  logic [NP-1:0]         gap;
  logic [NP-1:0]         exp_rd;
  int                    n_vec = 0;
  int                    n_err = 0;

  // Reference model: packet in progress, round-robin start, sequence number
  int m_busy, m_port, m_left, m_ptr, m_nub;

  task automatic add_pkt(input int port, input int len, input int prio);
    logic [WIDTH_DATA-1:0] w;
    w = {$urandom, $urandom};
    w[LEN_POS +: WIDTH_LENGTH]   = len[WIDTH_LENGTH-1:0];
    w[PRI_POS +: WIDTH_PRIORITY] = prio[WIDTH_PRIORITY-1:0];
    vq[port].push_back(w);
    for (int k = 0; k < len; k++) vq[port].push_back({$urandom, $urandom});
  endtask

  function automatic int head_len(input int p);
    return int'(vq[p][0][LEN_POS +: WIDTH_LENGTH]);
  endfunction

  function automatic int head_prio(input int p);
    return int'(vq[p][0][PRI_POS +: WIDTH_PRIORITY]);
  endfunction

  // Winner: first requester from m_ptr upward (with wrap), among the highest priority if enabled
  function automatic int pick();
    int maxp;
    int i;
    maxp = 0;
`ifdef PRIORITY_ARB_EN
    for (int p = 0; p < NP; p++)
      if (req_in[p] && head_prio(p) > maxp) maxp = head_prio(p);
`endif
    for (int k = 0; k < NP; k++) begin
      i = (m_ptr + k) % NP;
`ifdef PRIORITY_ARB_EN
      if (req_in[i] && head_prio(i) == maxp) return i;
`else
      if (req_in[i]) return i;
`endif
    end
    return -1;
  endfunction

  function automatic void finish_pkt(input int p);
    m_busy = 0;
    m_ptr  = (p + 1) % NP;
    m_nub  = (m_nub + 1) % NUB_MOD;
  endfunction

  function automatic void push_exp(input int p);
    exp_t e;
    e.d = {p[WIDTH_SEL-1:0], vq[p][0]};
    e.n = m_nub[WIDTH_SEL-1:0];
    sb.push_back(e);
  endfunction

  // One model cycle from the inputs currently driven
  task automatic model_step();
    int w;
    exp_rd = '0;
    if (!keep_in) begin
      if (m_busy == 0) begin
        w = pick();
        if (w >= 0) begin
          exp_rd[w] = 1'b1;
          push_exp(w);
          if (head_len(w) == 0) finish_pkt(w);
          else begin
            m_busy = 1; m_port = w; m_left = head_len(w);
          end
        end
      end else if (req_in[m_port]) begin
        exp_rd[m_port] = 1'b1;
        push_exp(m_port);
        m_left--;
        if (m_left == 0) finish_pkt(m_port);
      end
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < NP; i++) begin
      req_in[i] = (vq[i].size() > 0) && !gap[i];
      data_in[i*WIDTH_DATA +: WIDTH_DATA] = (vq[i].size() > 0) ? vq[i][0] : {$urandom, $urandom};
    end
  endtask

  task automatic cycle(input int p_keep, input int p_gap);
    @(negedge clk);
    keep_in = ($urandom_range(99) < p_keep);
    for (int i = 0; i < NP; i++) gap[i] = ($urandom_range(99) < p_gap);
    drive_inputs();
    #1;
    n_vec++;
    if (busy_out !== (m_busy != 0)) begin
      n_err++;
      $display("FAIL busy: got %b want %b", busy_out, (m_busy != 0));
    end
    model_step();
    n_vec++;
    if (rd_en_out !== exp_rd) begin
      n_err++;
      $display("FAIL rd_en: got %b want %b", rd_en_out, exp_rd);
    end
    @(posedge clk);
    for (int i = 0; i < NP; i++) if (exp_rd[i]) void'(vq[i].pop_front());
  endtask

  task automatic check_zero(input string tag);
    n_vec++;
    if ({data_out, nub_out, valid_out, busy_out, rd_en_out} !== '0) begin
      n_err++;
      $display("FAIL %s: got data=%h nub=%0d valid=%b busy=%b rd=%b want all 0",
               tag, data_out, nub_out, valid_out, busy_out, rd_en_out);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; keep_in = 1'b0; gap = '0;
    if (m_busy != 0) vq[m_port].delete();
    m_busy = 0; m_ptr = 0; m_nub = 0; m_left = 0; m_port = 0;
    req_in = '0;
    #1 check_zero("reset_async");
    @(posedge clk);
    #1 check_zero("reset_edge");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: each edge either holds under stall, delivers the next expected word, or delivers nothing with nothing owed
  initial begin
    logic                  ks, rs, pv;
    logic [WIDTH_PORT-1:0] pd;
    logic [WIDTH_SEL-1:0]  pn;
    exp_t                  e;
    pv = 1'b0; pd = '0; pn = '0;
    forever begin
      @(posedge clk);
      ks = keep_in;
      rs = rst_n;
      #1;
      if (!rs) begin
        sb.delete();
      end else if (ks) begin
        n_vec++;
        if ({valid_out, data_out, nub_out} !== {pv, pd, pn}) begin
          n_err++;
          $display("FAIL stall_hold: got v=%b d=%h n=%0d want v=%b d=%h n=%0d",
                   valid_out, data_out, nub_out, pv, pd, pn);
        end
      end else if (valid_out) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL extra_word: got d=%h n=%0d want no valid", data_out, nub_out);
        end else begin
          e = sb.pop_front();
          if (data_out !== e.d || nub_out !== e.n) begin
            n_err++;
            $display("FAIL word: got d=%h n=%0d want d=%h n=%0d", data_out, nub_out, e.d, e.n);
          end
        end
      end else begin
        n_vec++;
        if (sb.size() != 0) begin
          n_err++;
          $display("FAIL missing_word: got valid=0 want d=%h n=%0d", sb[0].d, sb[0].n);
          void'(sb.pop_front());
        end
      end
      pv = valid_out; pd = data_out; pn = nub_out;
    end
  end

  initial begin
    int budget;
    rst_n = 1'b0; keep_in = 1'b0; req_in = '0; data_in = '0; gap = '0; exp_rd = '0;
    m_busy = 0; m_port = 0; m_left = 0; m_ptr = 0; m_nub = 0;
    #2 check_zero("reset_init");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single packet on port 2, length 3
    add_pkt(2, 3, 0);
    repeat (6) cycle(0, 0);

    // Zero-length on port 1 followed by a packet on port 2
    add_pkt(1, 0, 0);
    add_pkt(2, 1, 0);
    repeat (5) cycle(0, 0);

    // Fairness with all ports loaded, length-1 packets; sequence wraps
    for (int r = 0; r < 5; r++)
      for (int p = 0; p < NP; p++) add_pkt(p, 1, 0);
    repeat (45) cycle(0, 0);

    // Priority contest (plain round-robin when the feature is off), then equal priorities
    add_pkt(0, 1, 1);
    add_pkt(3, 1, 2);
    repeat (6) cycle(0, 0);
    add_pkt(0, 0, 2);
    add_pkt(1, 0, 2);
    add_pkt(3, 0, 2);
    repeat (5) cycle(0, 0);

    // Back-pressure and underrun in the middle of a long packet
    add_pkt(1, 8, 0);
    repeat (3) cycle(0, 0);
    repeat (3) cycle(100, 0);
    repeat (2) cycle(0, 100);
    repeat (12) cycle(0, 0);

    // Randomized phases with varying stall and underrun rates
    for (int ph = 0; ph < 4; ph++) begin
      for (int c = 0; c < 300; c++) begin
        if ($urandom_range(99) < 30) begin
          int p;
          p = $urandom_range(NP - 1);
          if (vq[p].size() < 40)
            add_pkt(p, $urandom_range((1 << WIDTH_LENGTH) - 1), $urandom_range((1 << WIDTH_PRIORITY) - 1));
        end
        cycle((ph == 1 || ph == 3) ? 25 : 0, (ph >= 2) ? 25 : 0);
      end
    end

    // Reset in the middle of a packet
    add_pkt(3, 12, 0);
    budget = 0;
    while (!(m_busy != 0 && m_left > 2) && budget < 1000) begin
      cycle(0, 0);
      budget++;
    end
    n_vec++;
    if (budget >= 1000) begin
      n_err++;
      $display("FAIL mid_reset_setup: got no packet in progress want busy within 1000 cycles");
    end
    do_reset();
    add_pkt(0, 2, 0);
    add_pkt(2, 0, 0);

    // Drain everything left
    budget = 0;
    while (budget < 3000) begin
      int left;
      left = m_busy;
      for (int p = 0; p < NP; p++) left += vq[p].size();
      if (left == 0) break;
      cycle(0, 0);
      budget++;
    end
    repeat (3) cycle(0, 0);
    n_vec++;
    if (budget >= 3000) begin
      n_err++;
      $display("FAIL drain: got queues non-empty want empty within 3000 cycles");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
